systolic_drain: RTL and testbench
=================================

# systolic_drain

Output-side controller for the systolic MAC array. Once the load/MAC controller has emptied its input FIFOs, this block waits for the array to flush, then unloads the size×size accumulator results. It shifts the PE accumulator grid down one row at a time and serializes each bottom row onto a val/rdy stream, one column per beat. It is the consumer of the array's results, where the load controller is the producer of its operands.

## Interface
Parameters:
- size, 16, array dimension (rows = columns = size); must be at least 2
- nbits, 32, accumulator / output message width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: MAC phase has consumed the last FIFO entries; accepted only in IDLE or DONE
- col_data  in  nbits×size (unpacked array [size])  bottom-row PE accumulators, column i at index i
- pe_shift  out  1  shifts every PE accumulator down one row; the top row loads zero
- out_msg  out  nbits  result word
- out_val  out  1  out_msg valid
- out_rdy  in  1  downstream accepts out_msg
- busy  out  1  high in FLUSH or SEND
- done  out  1  high in DONE

## Operation
- States: IDLE, FLUSH, SEND, DONE (one-hot, 4 bits). Reset state is IDLE.
- IDLE:
  - start moves to FLUSH.
  - flush_cnt and the row and column counters are cleared.
- FLUSH:
  - flush_cnt increments every cycle.
  - When flush_cnt == 2*size-2, the next state is SEND. FLUSH therefore lasts exactly 2*size-1 cycles, which is the skew latency of the last operand reaching PE[size-1][size-1].
- SEND:
  - out_val = 1 and out_msg = col_data[col]. Both are combinational from state and col.
  - A transfer occurs when out_val && out_rdy.
  - On transfer with col < size-1: col increments.
  - On transfer with col == size-1: col wraps to 0 and pe_shift pulses in the same cycle. If row == size-1, the next state is DONE; otherwise row increments.
  - With no transfer, out_msg, col, row and the state all hold, and pe_shift = 0.
- DONE:
  - done = 1 and out_val = 0.
  - start moves to FLUSH and clears all counters.
  - The array is already zeroed by size zero-filled shifts, so no separate clear is needed.
- start is ignored in FLUSH and SEND.
- out_rdy is ignored when out_val = 0.
- Stream order is row-major from the bottom: beat k carries the original PE row size-1-(k/size), column k%size.
- Counter widths:
  - col and row: $clog2(size) bits.
  - flush_cnt: $clog2(2*size) bits.
  - No counter ever exceeds its terminal value.

## Timing
- Output values during and after reset: out_val 0, pe_shift 0, busy 0, done 0, out_msg = col_data[0] (don't-care).
- Latency: start at cycle t gives the first out_val at t+1+(2*size-1), i.e. t+2*size with FLUSH occupying t+1..t+2*size-1.
- Throughput: one word per cycle while out_rdy = 1. With out_rdy held high, SEND lasts size² cycles and DONE is entered exactly size² cycles after SEND is entered.
- pe_shift is single-cycle and coincident with the final-column handshake. col_data must present the new row on the following cycle, since the PE registers update on that clock edge.
- Simultaneous events:
  - start in DONE while out_rdy = 1 has no stream effect, because out_val = 0.
  - rst has priority over everything. Reset in FLUSH or SEND returns to IDLE next cycle, drops out_val and suppresses pe_shift in that cycle. The partially shifted array is not restored.
- Backpressure: out_msg must be stable while out_val && !out_rdy. col_data is stable because pe_shift is low.

## Structure
- Shared header SystolicDefs holds the state encodings (IDLE/FLUSH/SEND/DONE) alongside the load controller's LOAD/MAC/OUT encodings.
- Sub-module SystolicDrainCnt: a parameterized counter with clear, enable and terminal-count flag, instanced three times (flush, col, row).
- The FSM and the column mux stay in systolic_drain.

## Test plan
- Reset: hold rst 3 cycles mid-SEND, size=2 → out_val=0, pe_shift=0, busy=0, done=0 on the cycle after the rst edge; IDLE afterwards.
- Basic drain, size=2, out_rdy=1, array model rows {[1,2],[3,4]} → start at t0; first out_val at t0+4; stream 3,4,1,2; pe_shift on beats 2 and 4; done at t0+8.
- Backpressure, size=4: out_rdy toggled 1,0,0,1 repeating → 16 words in the correct order, no duplicates or drops, out_msg stable while stalled, pe_shift only on handshakes.
- Flush length, size=4: start with out_rdy=1 → exactly 7 FLUSH cycles (busy=1, out_val=0), first valid on cycle 8 after start.
- Ignored start: pulse start during FLUSH and mid-SEND → no counter reset, stream unchanged. Start in DONE → new drain, and the second drain of a zero array outputs 16 zeros.
- Reset mid-operation: rst during the third beat, size=2 → IDLE next cycle. A new start produces a full 4-beat drain with correct latency.

Source files
------------

// File: rtl/systolic_drain_pkg.sv
// Shared systolic-array controller encodings: drain FSM (IDLE/FLUSH/SEND/DONE)
// and the load controller's LOAD/MAC/OUT states, all one-hot.
package systolic_drain_pkg;

  localparam int unsigned DRAIN_STATE_W = 4;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_FLUSH = 4'b0010;
  localparam logic [3:0] ST_SEND  = 4'b0100;
  localparam logic [3:0] ST_DONE  = 4'b1000;

  localparam logic [2:0] LD_LOAD = 3'b001;
  localparam logic [2:0] LD_MAC  = 3'b010;
  localparam logic [2:0] LD_OUT  = 3'b100;

  // Last flush_cnt value: operand skew to reach PE[size-1][size-1].
  function automatic int unsigned flush_term(input int unsigned size);
    return 2 * size - 2;
  endfunction

endpackage

// File: rtl/systolic_drain_cnt.sv
// Up-counter with clear (priority), enable and terminal-count flag; wraps to 0
// on an enabled terminal count. Zero latency on the flag, no backpressure.
module systolic_drain_cnt #(
  parameter int unsigned width = 4,
  parameter int unsigned term  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [width-1:0] cnt,
  output logic             tc
);

  localparam logic [width-1:0] term_v = width'(term);

  logic [width-1:0] cnt_d;
  logic [width-1:0] cnt_q;

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term_v);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/systolic_drain.sv
// Drains the size x size accumulator grid bottom row first, one column per beat;
// first word 2*size cycles after start, out_msg/col held while out_val && !out_rdy.
module systolic_drain
  import systolic_drain_pkg::*;
#(
  parameter int unsigned size  = 16,
  parameter int unsigned nbits = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [nbits-1:0] col_data [size],
  output logic             pe_shift,
  output logic [nbits-1:0] out_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             busy,
  output logic             done
);

  localparam int unsigned cw = $clog2(size);
  localparam int unsigned fw = $clog2(2 * size);

  logic [DRAIN_STATE_W-1:0] state_d;
  logic [DRAIN_STATE_W-1:0] state_q;

  logic is_idle, is_flush, is_send, is_done;
  logic cnt_clr, xfer;
  logic flush_tc, col_tc, row_tc;
  logic [fw-1:0] flush_cnt;
  logic [cw-1:0] col_cnt;
  logic [cw-1:0] row_cnt;

  assign is_idle  = (state_q == ST_IDLE);
  assign is_flush = (state_q == ST_FLUSH);
  assign is_send  = (state_q == ST_SEND);
  assign is_done  = (state_q == ST_DONE);

  assign cnt_clr = is_idle | (is_done & start);
  assign xfer    = is_send & out_rdy & ~rst;

  systolic_drain_cnt #(.width(fw), .term(flush_term(size))) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (is_flush),
    .cnt (flush_cnt),
    .tc  (flush_tc)
  );

  systolic_drain_cnt #(.width(cw), .term(size - 1)) u_col_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (xfer),
    .cnt (col_cnt),
    .tc  (col_tc)
  );

  systolic_drain_cnt #(.width(cw), .term(size - 1)) u_row_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (xfer & col_tc),
    .cnt (row_cnt),
    .tc  (row_tc)
  );

  // Flush and row counts only feed their terminal flags; values kept for debug.
  logic unused_cnt;
  assign unused_cnt = ^{flush_cnt, row_cnt};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_tc) state_d = ST_SEND;
      ST_SEND:  if (xfer && col_tc && row_tc) state_d = ST_DONE;
      ST_DONE:  if (start) state_d = ST_FLUSH;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are masked by rst so a reset in SEND drops the stream immediately.
  assign out_msg  = col_data[col_cnt];
  assign out_val  = is_send & ~rst;
  assign pe_shift = xfer & col_tc;
  assign busy     = (is_flush | is_send) & ~rst;
  assign done     = is_done & ~rst;

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain at size=2 and size=4 with a PE-grid model and a
// row-major-from-bottom stream reference computed from the loaded matrix.
module tb_systolic_drain;

  localparam int NB = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, start, rdy, val, shift, busy, done, ld_en;
  logic [1:0][NB-1:0] msg;
  logic [NB-1:0] col2 [2];
  logic [NB-1:0] col4 [4];

  // pe: accumulator grid seen by each DUT; ref_mat: matrix the stream must reproduce
  logic [NB-1:0] pe      [2][4][4];
  logic [NB-1:0] ref_mat [2][4][4];

  int checks = 0;
  int errors = 0;

  systolic_drain #(.size(2), .nbits(NB)) dut2 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .col_data(col2),
    .pe_shift(shift[0]), .out_msg(msg[0]), .out_val(val[0]), .out_rdy(rdy[0]),
    .busy(busy[0]), .done(done[0])
  );

  systolic_drain #(.size(4), .nbits(NB)) dut4 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .col_data(col4),
    .pe_shift(shift[1]), .out_msg(msg[1]), .out_val(val[1]), .out_rdy(rdy[1]),
    .busy(busy[1]), .done(done[1])
  );

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ld_en[d]) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            pe[d][r][c] <= ref_mat[d][r][c];
      end else if (shift[d]) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 3; r > 0; r--) pe[d][r][c] <= pe[d][r-1][c];
          pe[d][0][c] <= '0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) col2[i] = pe[0][1][i];
    for (int i = 0; i < 4; i++) col4[i] = pe[1][3][i];
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_random(input int d);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ref_mat[d][r][c] = $urandom;
    ld_en[d] = 1'b1;
    tick();
    ld_en[d] = 1'b0;
  endtask

  // Pulses start, runs with the given out_rdy mode and checks every cycle.
  task automatic drain(input int d, input int mode, input bit poke, input string tag);
    int sz, n, k, j;
    bit r, hv;
    logic exp_sh;
    logic [NB-1:0] held, exp_w;
    sz = (d == 0) ? 2 : 4;
    n = sz * sz;
    k = 0;
    hv = 1'b0;
    held = '0;
    start[d] = 1'b1;
    rdy[d] = 1'b1;
    tick();
    j = 1;
    while (k < n && j < 200) begin
      case (mode)
        0: r = 1'b1;
        1: r = ((j % 4) == 0) || ((j % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      rdy[d] = r;
      start[d] = poke && (j == 3 || j == 2 * sz + 5);
      #1;
      if (j < 2 * sz) begin
        checks++;
        if (val[d] !== 1'b0 || busy[d] !== 1'b1 || shift[d] !== 1'b0) begin
          errors++;
          $display("FAIL %s flush j=%0d: val=%b busy=%b shift=%b, required val=0 busy=1 shift=0",
                   tag, j, val[d], busy[d], shift[d]);
        end
      end else begin
        exp_w = ref_mat[d][sz-1-k/sz][k%sz];
        exp_sh = r && ((k % sz) == sz - 1);
        checks++;
        if (val[d] !== 1'b1 || busy[d] !== 1'b1) begin
          errors++;
          $display("FAIL %s send_valid j=%0d: val=%b busy=%b, required 1 1", tag, j, val[d], busy[d]);
        end
        checks++;
        if (msg[d] !== exp_w) begin
          errors++;
          $display("FAIL %s beat %0d: got %h, required %h", tag, k, msg[d], exp_w);
        end
        checks++;
        if (shift[d] !== exp_sh) begin
          errors++;
          $display("FAIL %s pe_shift beat %0d: got %b, required %b", tag, k, shift[d], exp_sh);
        end
        if (hv) begin
          checks++;
          if (msg[d] !== held) begin
            errors++;
            $display("FAIL %s stall_stable beat %0d: got %h, required %h", tag, k, msg[d], held);
          end
        end
        if (r) begin
          k++;
          hv = 1'b0;
        end else begin
          held = msg[d];
          hv = 1'b1;
        end
      end
      tick();
      j++;
    end
    start[d] = 1'b0;
    rdy[d] = 1'b1;
    #1;
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL %s timeout: beats=%0d, required %0d", tag, k, n);
    end
    checks++;
    if (done[d] !== 1'b1 || val[d] !== 1'b0 || busy[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s done_state: done=%b val=%b busy=%b, required 1 0 0", tag, done[d], val[d], busy[d]);
    end
    if (mode == 0) begin
      checks++;
      if (j != 2 * sz + n) begin
        errors++;
        $display("FAIL %s done_cycle: got t0+%0d, required t0+%0d", tag, j, 2 * sz + n);
      end
    end
    // A complete drain shifts size zero rows into the grid.
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        ref_mat[d][rr][cc] = '0;
  endtask

  // Starts a drain with out_rdy=1 and stops at the negedge showing beat 'beat'.
  task automatic run_to_beat(input int d, input int beat);
    int k, j;
    k = 0;
    j = 0;
    start[d] = 1'b1;
    rdy[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    while (!(val[d] === 1'b1 && k == beat) && j < 100) begin
      if (val[d] === 1'b1) k++;
      tick();
      j++;
    end
    checks++;
    if (j >= 100) begin
      errors++;
      $display("FAIL run_to_beat timeout: beats=%0d, required %0d", k, beat);
    end
  endtask

  task automatic test_reset();
    rst = 2'b11;
    start = 2'b00;
    rdy = 2'b11;
    ld_en = 2'b00;
    repeat (3) begin
      tick();
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (val[d] !== 1'b0 || shift[d] !== 1'b0 || busy[d] !== 1'b0 || done[d] !== 1'b0) begin
          errors++;
          $display("FAIL reset_outputs dut%0d: val=%b shift=%b busy=%b done=%b, required 0000",
                   d, val[d], shift[d], busy[d], done[d]);
        end
      end
    end
    rst = 2'b00;
    tick();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (val[d] !== 1'b0 || busy[d] !== 1'b0 || done[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle dut%0d: val=%b busy=%b done=%b, required 000", d, val[d], busy[d], done[d]);
      end
    end
  endtask

  task automatic test_basic();
    ref_mat[0][0][0] = 1;
    ref_mat[0][0][1] = 2;
    ref_mat[0][1][0] = 3;
    ref_mat[0][1][1] = 4;
    ld_en[0] = 1'b1;
    tick();
    ld_en[0] = 1'b0;
    drain(0, 0, 1'b0, "basic");
  endtask

  task automatic test_flush_length();
    load_random(1);
    drain(1, 0, 1'b0, "flush_len");
  endtask

  task automatic test_backpressure();
    load_random(1);
    drain(1, 1, 1'b0, "backpressure");
  endtask

  task automatic test_ignored_start();
    load_random(1);
    drain(1, 2, 1'b1, "ignored_start");
    drain(1, 0, 1'b0, "zero_drain");
  endtask

  task automatic test_reset_mid_send();
    load_random(0);
    run_to_beat(0, 1);
    rst[0] = 1'b1;
    repeat (3) begin
      tick();
      #1;
      checks++;
      if (val[0] !== 1'b0 || shift[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_send: val=%b shift=%b busy=%b done=%b, required 0000",
                 val[0], shift[0], busy[0], done[0]);
      end
    end
    rst[0] = 1'b0;
    repeat (2) begin
      #1;
      checks++;
      if (val[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_send_idle: val=%b busy=%b done=%b, required 000", val[0], busy[0], done[0]);
      end
      tick();
    end
  endtask

  task automatic test_reset_third_beat();
    load_random(0);
    run_to_beat(0, 2);
    checks++;
    if (msg[0] !== ref_mat[0][0][0]) begin
      errors++;
      $display("FAIL third_beat_data: got %h, required %h", msg[0], ref_mat[0][0][0]);
    end
    rst[0] = 1'b1;
    #1;
    checks++;
    if (val[0] !== 1'b0 || shift[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_third_beat_mask: val=%b shift=%b, required 00", val[0], shift[0]);
    end
    tick();
    rst[0] = 1'b0;
    #1;
    checks++;
    if (val[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_third_beat_idle: val=%b busy=%b done=%b, required 000", val[0], busy[0], done[0]);
    end
    load_random(0);
    drain(0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      load_random(1);
      drain(1, 2, 1'b0, "random4");
      load_random(0);
      drain(0, 2, 1'b0, "random2");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush_length();
    test_backpressure();
    test_ignored_start();
    test_reset_mid_send();
    test_reset_third_beat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
